// File: rtl/reg_pipe_pkg.sv
// reg_pipe_pkg: shared defaults and occupancy-width helper for reg_pipe.
package reg_pipe_pkg;
  localparam int DEF_WIDTH  = 8;
  localparam int DEF_DEPTH  = 4;
  localparam bit DEF_INVERT = 1'b1;
  function automatic int OCC_W(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/reg_pipe_stage.sv
// reg_pipe_stage: one data+valid register; data loads only when a valid beat advances in.
module reg_pipe_stage
  import reg_pipe_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             v_in,
  input  logic [WIDTH-1:0] d_in,
  output logic             v_out,
  output logic [WIDTH-1:0] d_out
);
  logic             v_q, v_d;
  logic [WIDTH-1:0] data_q, data_d;
  always_comb begin
    v_d    = adv ? v_in : v_q;
    data_d = (adv & v_in) ? d_in : data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q    <= 1'b0;
      data_q <= RESET_VAL;
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
    end
  end
  assign v_out = v_q;
  assign d_out = data_q;
endmodule

// File: rtl/reg_pipe.sv
// reg_pipe: elastic DEPTH-stage retiming pipeline with collapsing bubbles and optional inversion.
// Define REG_PIPE_OCC_EN to add the registered occupancy count port occ.
module reg_pipe
  import reg_pipe_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               DEPTH     = DEF_DEPTH,
  parameter bit               INVERT    = DEF_INVERT,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           d,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           q,
  output logic                       out_valid,
  input  logic                       out_ready
`ifdef REG_PIPE_OCC_EN
  ,
  output logic [OCC_W(DEPTH)-1:0]    occ
`endif
);
  logic [DEPTH-1:0] v, adv;
  logic [WIDTH-1:0] data [DEPTH];
  logic             in_xfer, out_xfer;
  // a stage may advance if anything downstream of it moves or it holds a bubble
  always_comb begin
    adv[DEPTH-1] = out_ready | ~v[DEPTH-1];
    for (int i = DEPTH - 2; i >= 0; i--) adv[i] = adv[i+1] | ~v[i];
  end
  assign in_ready  = adv[0] & ~rst;
  assign in_xfer   = in_valid & in_ready;
  assign out_valid = v[DEPTH-1];
  assign q         = data[DEPTH-1];
  assign out_xfer  = out_valid & out_ready;
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             v_in;
    logic [WIDTH-1:0] d_in;
    if (i == 0) begin : g_head
      assign v_in = in_xfer;
      assign d_in = INVERT ? ~d : d;
    end else begin : g_body
      assign v_in = v[i-1];
      assign d_in = data[i-1];
    end
    reg_pipe_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
      .clk   (clk),
      .rst   (rst),
      .adv   (adv[i]),
      .v_in  (v_in),
      .d_in  (d_in),
      .v_out (v[i]),
      .d_out (data[i])
    );
  end
`ifdef REG_PIPE_OCC_EN
  localparam int OW = OCC_W(DEPTH);
  logic [OW-1:0] occ_q, occ_d;
  always_comb occ_d = occ_q + OW'(in_xfer) - OW'(out_xfer);
  always_ff @(posedge clk) begin
    if (rst) occ_q <= '0;
    else     occ_q <= occ_d;
  end
  assign occ = occ_q;
`endif
endmodule

// File: tb/tb_reg_pipe.sv
// tb_reg_pipe: checks reg_pipe (4-stage inverting and 1-stage plain) against a queue model.
module tb_reg_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic            rst = 1'b1;
  logic [1:0]      iv = '0, ord = '0, ird, ov;
  logic [1:0][7:0] dd = '0, qq;
`ifdef REG_PIPE_OCC_EN
  logic [2:0] occ0;
  logic       occ1;
`endif
  reg_pipe #(.WIDTH(8), .DEPTH(4), .INVERT(1), .RESET_VAL(8'h00)) u0 (
    .clk(clk), .rst(rst), .d(dd[0]), .in_valid(iv[0]), .in_ready(ird[0]),
    .q(qq[0]), .out_valid(ov[0]), .out_ready(ord[0])
`ifdef REG_PIPE_OCC_EN
    , .occ(occ0)
`endif
  );
  reg_pipe #(.WIDTH(8), .DEPTH(1), .INVERT(0), .RESET_VAL(8'h00)) u1 (
    .clk(clk), .rst(rst), .d(dd[1]), .in_valid(iv[1]), .in_ready(ird[1]),
    .q(qq[1]), .out_valid(ov[1]), .out_ready(ord[1])
`ifdef REG_PIPE_OCC_EN
    , .occ(occ1)
`endif
  );
  // model: per pipe, a FIFO of beats with the edge number at which each was accepted
  logic [7:0] md[2][$];
  int         mt[2][$];
  bit         seen[2];
  bit         started;
  int         e;
  int         n_vec, n_bad;
  logic [7:0] obs[$];
  function automatic int dep(input int i);
    return i == 0 ? 4 : 1;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  // the oldest beat always has empty stages ahead, so it reaches q DEPTH-1 edges after acceptance
  task automatic tick();
    bit exp_ir, exp_ov;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      exp_ir = !rst && (md[i].size() < dep(i) || ord[i]);
      exp_ov = md[i].size() > 0 && (e - mt[i][0] >= dep(i) - 1);
      if (started) begin
        chk($sformatf("in_ready%0d", i), 32'(ird[i]), 32'(exp_ir));
        chk($sformatf("out_valid%0d", i), 32'(ov[i]), 32'(exp_ov));
        if (exp_ov) chk($sformatf("q%0d", i), 32'(qq[i]), 32'(md[i][0]));
        else if (!seen[i]) chk($sformatf("q_reset%0d", i), 32'(qq[i]), 32'h0);
`ifdef REG_PIPE_OCC_EN
        chk($sformatf("occ%0d", i), i == 0 ? 32'(occ0) : 32'(occ1), 32'(md[i].size()));
`endif
      end
      seen[i] = seen[i] | exp_ov;
      if (rst) begin
        md[i].delete();
        mt[i].delete();
        seen[i] = 1'b0;
      end else begin
        if (exp_ov && ord[i]) begin
          void'(md[i].pop_front());
          void'(mt[i].pop_front());
        end
        if (iv[i] && exp_ir) begin
          md[i].push_back(i == 0 ? ~dd[i] : dd[i]);
          mt[i].push_back(e + 1);
        end
      end
    end
    if (rst) started = 1'b1;
    e++;
    @(posedge clk);
    #1;
  endtask
  initial begin
    int lat, j, c;
    bit acc;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(ov[0]), 32'h0);
    chk("rst_q", 32'(qq[0]), 32'h0);
    chk("rst_in_ready", 32'(ird[0]), 32'h1);
`ifdef REG_PIPE_OCC_EN
    chk("rst_occ", 32'(occ0), 32'h0);
`endif
    ord = 2'b11;
    dd[0] = 8'h00;
    iv[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    lat = 0;
    while (!ov[0] && lat < 10) begin
      tick();
      lat++;
    end
    chk("latency", 32'(lat), 32'd3);
    chk("latency_q", 32'(qq[0]), 32'hFF);
    tick();
    chk("latency_pulse", 32'(ov[0]), 32'h0);
    obs.delete();
    for (int b = 1; b <= 16; b++) begin
      dd[0] = 8'(b);
      iv[0] = 1'b1;
      #1;
      chk("stream_ready", 32'(ird[0]), 32'h1);
      tick();
      if (ov[0]) obs.push_back(qq[0]);
    end
    iv[0] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (ov[0]) obs.push_back(qq[0]);
    end
    chk("stream_count", 32'(obs.size()), 32'd16);
    for (int k = 0; k < obs.size() && k < 16; k++) chk("stream_q", 32'(obs[k]), 32'(8'hFE - 8'(k)));
    ord[0] = 1'b0;
    j = 0;
    for (int k = 0; k < 8; k++) begin
      dd[0] = 8'h20 + 8'(j);
      iv[0] = 1'b1;
      #1;
      acc = ird[0];
      tick();
      if (acc) j++;
    end
    chk("bp_accepted", 32'(j), 32'd4);
    chk("bp_in_ready", 32'(ird[0]), 32'h0);
    chk("bp_out_valid", 32'(ov[0]), 32'h1);
    chk("bp_q_held", 32'(qq[0]), 32'hDF);
`ifdef REG_PIPE_OCC_EN
    chk("bp_occ", 32'(occ0), 32'd4);
`endif
    ord[0] = 1'b1;
    obs.delete();
    c = 0;
    while (j < 6 && c < 20) begin
      dd[0] = 8'h20 + 8'(j);
      iv[0] = 1'b1;
      #1;
      acc = ird[0];
      if (ov[0]) obs.push_back(qq[0]);
      tick();
      if (acc) j++;
      c++;
    end
    iv[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (ov[0]) obs.push_back(qq[0]);
      tick();
    end
    chk("bp_all_sent", 32'(j), 32'd6);
    chk("bp_count", 32'(obs.size()), 32'd6);
    for (int k = 0; k < obs.size() && k < 6; k++) chk("bp_order", 32'(obs[k]), 32'(8'hDF - 8'(k)));
    ord[0] = 1'b0;
    dd[0] = 8'h30;
    iv[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    tick();
    tick();
    dd[0] = 8'h31;
    iv[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    tick();
    tick();
    chk("bubble_out_valid", 32'(ov[0]), 32'h1);
    chk("bubble_q", 32'(qq[0]), 32'hCF);
    chk("bubble_in_ready", 32'(ird[0]), 32'h1);
`ifdef REG_PIPE_OCC_EN
    chk("bubble_occ", 32'(occ0), 32'd2);
`endif
    iv[0] = 1'b1;
    dd[0] = 8'h32;
    tick();
    dd[0] = 8'h33;
    tick();
    chk("full_stall_ready", 32'(ird[0]), 32'h0);
    ord[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      dd[0] = 8'h40 + 8'(k);
      #1;
      chk("full_ready", 32'(ird[0]), 32'h1);
      tick();
`ifdef REG_PIPE_OCC_EN
      chk("full_occ", 32'(occ0), 32'd4);
`endif
    end
    iv[0] = 1'b0;
    repeat (8) tick();
    ord[0] = 1'b0;
    iv[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      dd[0] = 8'h50 + 8'(k);
      tick();
    end
    iv[0] = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("flush_out_valid", 32'(ov[0]), 32'h0);
    chk("flush_q", 32'(qq[0]), 32'h0);
    chk("flush_in_ready", 32'(ird[0]), 32'h1);
`ifdef REG_PIPE_OCC_EN
    chk("flush_occ", 32'(occ0), 32'h0);
`endif
    ord[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("flush_no_old", 32'(ov[0]), 32'h0);
    end
    dd[1] = 8'hA5;
    iv[1] = 1'b1;
    ord[1] = 1'b1;
    tick();
    chk("d1_valid", 32'(ov[1]), 32'h1);
    chk("d1_q", 32'(qq[1]), 32'hA5);
    for (int b = 0; b < 8; b++) begin
      dd[1] = 8'h60 + 8'(b);
      #1;
      chk("d1_ready", 32'(ird[1]), 32'h1);
      tick();
      chk("d1_tput_valid", 32'(ov[1]), 32'h1);
      chk("d1_tput_q", 32'(qq[1]), 32'(8'h60 + 8'(b)));
    end
    iv[1] = 1'b0;
    tick();
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(149) == 0);
      for (int i = 0; i < 2; i++) begin
        iv[i]  = ($urandom_range(3) != 0);
        ord[i] = ((n / 400) % 2 == 0) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
        dd[i]  = 8'($urandom);
      end
      tick();
    end
    rst = 1'b0;
    iv = '0;
    ord = 2'b11;
    repeat (6) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
